csv_acc_stage: RTL and testbench

CSV_ACC_STAGE -- requirements
Module: csv_acc_stage

---
 rtl/csv_acc_stage.sv | 135 +++++++++++++
 tb/tb_csv_acc_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/csv_acc_stage.sv
// csv_acc_stage: carry-save accumulation stage.
//
// Sums the beats of a packet with one 3:2 compressor row per beat. The sum
// and carry vectors are kept in redundant form, so no carry-propagate adder
// sits on the accumulation path. On the last beat the pending S/C pair and the
// multiplicand Y are handed to a one-entry output buffer. A downstream unit
// forms (XS + XC) * YO from that buffer.
//
// Ports
//   CLK       in   clock; all state updates on the rising edge
//   RSTN      in   asynchronous active-low reset
//   A         in   addend beat (widthX)
//   Y         in   multiplicand, captured with the last beat (widthY)
//   InValid   in   A/Y/InLast carry a beat
//   InLast    in   beat is the final term of its packet
//   InReady   out  beat is accepted this cycle
//   XS, XC    out  carry-save sum/carry of the completed packet (widthX)
//   YO        out  Y captured with the packet's last beat (widthY)
//   OutValid  out  XS/XC/YO hold a complete packet
//   OutReady  in   consumer takes the output this cycle
//
// All arithmetic is modulo 2^widthX. widthX must be at least 2 and must not
// exceed widthY.
module csv_acc_stage #(
  parameter int unsigned widthX = 8,
  parameter int unsigned widthY = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [widthX-1:0] A,
  input  logic [widthY-1:0] Y,
  input  logic              InValid,
  input  logic              InLast,
  output logic              InReady,
  output logic [widthX-1:0] XS,
  output logic [widthX-1:0] XC,
  output logic [widthY-1:0] YO,
  output logic              OutValid,
  input  logic              OutReady
);

  // StEmpty corresponds to First=1, and StAcc corresponds to First=0.
  typedef enum logic [0:0] {StEmpty, StAcc} acc_state_e;

  acc_state_e        state_q, state_d;
  logic [widthX-1:0] s_q, s_d;
  logic [widthX-1:0] c_q, c_d;
  logic [widthX-1:0] xs_q, xs_d;
  logic [widthX-1:0] xc_q, xc_d;
  logic [widthY-1:0] yo_q, yo_d;
  logic              out_valid_q, out_valid_d;

  logic              in_fire;
  logic              out_fire;
  logic [widthX-1:0] s_new;
  logic [widthX-1:0] c_new;
  logic [widthX-1:0] maj;

  // A last beat must wait for space in the output buffer. A non-last beat
  // only touches the accumulator, so it is always accepted.
  assign InReady  = ~InLast | ~out_valid_q | OutReady;
  assign in_fire  = InValid & InReady;
  assign out_fire = out_valid_q & OutReady;

  // One compressor row. The carry out of the top bit is dropped, which
  // gives the modulo-2^widthX behaviour.
  always_comb begin
    maj = (s_q & c_q) | (s_q & A) | (c_q & A);
    if (state_q == StEmpty) begin
      s_new = A;
      c_new = '0;
    end else begin
      s_new = s_q ^ c_q ^ A;
      c_new = {maj[widthX-2:0], 1'b0};
    end
  end

  // The accumulator and the output buffer advance independently. A packet
  // can keep accumulating while the buffer waits for the consumer.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    xs_d        = xs_q;
    xc_d        = xc_q;
    yo_d        = yo_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (InLast) begin
        // Hand off the completed packet. The accumulator goes back to empty,
        // and the next beat overwrites S/C.
        state_d     = StEmpty;
        xs_d        = s_new;
        xc_d        = c_new;
        yo_d        = Y;
        out_valid_d = 1'b1;
      end else begin
        state_d = StAcc;
        s_d     = s_new;
        c_d     = c_new;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StEmpty;
      s_q         <= '0;
      c_q         <= '0;
      xs_q        <= '0;
      xc_q        <= '0;
      yo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      xs_q        <= xs_d;
      xc_q        <= xc_d;
      yo_q        <= yo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign XS       = xs_q;
  assign XC       = xc_q;
  assign YO       = yo_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_csv_acc_stage.sv
// Directed testbench for csv_acc_stage (widthX = widthY = 8).
module tb_csv_acc_stage;

  logic       CLK;
  logic       RSTN;
  logic [7:0] A;
  logic [7:0] Y;
  logic       InValid;
  logic       InLast;
  logic       InReady;
  logic [7:0] XS;
  logic [7:0] XC;
  logic [7:0] YO;
  logic       OutValid;
  logic       OutReady;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;

  csv_acc_stage #(
    .widthX(8),
    .widthY(8)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .A       (A),
    .Y       (Y),
    .InValid (InValid),
    .InLast  (InLast),
    .InReady (InReady),
    .XS      (XS),
    .XC      (XC),
    .YO      (YO),
    .OutValid(OutValid),
    .OutReady(OutReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts delivered packets so that losses and duplicates show up.
  always @(posedge CLK) begin
    if (RSTN && OutValid && OutReady) out_cnt <= out_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a beat and holds it until accepted (bounded). The task returns
  // 1 time unit after the edge at which the transfer happened.
  task automatic send(input logic [7:0] a, input logic last, input logic [7:0] y);
    int n;
    A = a;
    Y = y;
    InLast = last;
    InValid = 1'b1;
    n = 0;
    #1;
    while (!InReady && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed InReady %0b expected 1", InReady);
    end
    @(posedge CLK);
    #1;
    InValid = 1'b0;
    InLast = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RSTN = 1'b0;
    A = '0;
    Y = '0;
    InValid = 1'b0;
    InLast = 1'b1;
    OutReady = 1'b1;
    #1;
    chk("rst_outvalid", 32'(OutValid), 32'h0);
    chk("rst_inready", 32'(InReady), 32'h1);
    chk("rst_xs", 32'(XS), 32'h0);
    chk("rst_xc", 32'(XC), 32'h0);
    chk("rst_yo", 32'(YO), 32'h0);
    InLast = 1'b0;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    idle(1);
    chk("post_rst_inready", 32'(InReady), 32'h1);

    // 3 + 5 + 7 = 15; S/C go 3/0, then 6/2, then 3/12
    send(8'd3, 1'b0, 8'h0);
    send(8'd5, 1'b0, 8'h0);
    send(8'd7, 1'b1, 8'd4);
    chk("p1_valid", 32'(OutValid), 32'h1);
    chk("p1_xs", 32'(XS), 32'd3);
    chk("p1_xc", 32'(XC), 32'd12);
    chk("p1_sum", 32'(8'(XS + XC)), 32'd15);
    chk("p1_yo", 32'(YO), 32'd4);
    idle(1);
    chk("p1_drained", 32'(OutValid), 32'h0);

    // Single-beat packet
    send(8'hAB, 1'b1, 8'h10);
    chk("single_xs", 32'(XS), 32'hAB);
    chk("single_xc", 32'(XC), 32'h00);
    chk("single_yo", 32'(YO), 32'h10);
    idle(1);

    // Wrap-around: 0xFF + 0x02 = 0x101, which reduces to 0x01
    send(8'hFF, 1'b0, 8'h0);
    send(8'h02, 1'b1, 8'h22);
    chk("wrap_xs", 32'(XS), 32'hFD);
    chk("wrap_xc", 32'(XC), 32'h04);
    chk("wrap_sum", 32'(8'(XS + XC)), 32'h01);
    idle(1);

    // Idle cycles between beats leave the accumulator alone: 5 + 6 = 11
    send(8'h05, 1'b0, 8'h0);
    A = 8'h77;
    idle(2);
    send(8'h06, 1'b1, 8'h01);
    chk("gap_xs", 32'(XS), 32'h03);
    chk("gap_xc", 32'(XC), 32'h08);
    idle(1);

    // Backpressure. Packet 1 = 3 + 1 (XS=2, XC=2) and stays held.
    OutReady = 1'b0;
    send(8'h03, 1'b0, 8'h0);
    send(8'h01, 1'b1, 8'h07);
    chk("bp_p1_valid", 32'(OutValid), 32'h1);
    // Non-last beats of packet 2 still go through
    send(8'h10, 1'b0, 8'h0);
    chk("bp_nonlast_ready", 32'(InReady), 32'h1);
    send(8'h20, 1'b0, 8'h0);
    A = 8'h30;
    Y = 8'h55;
    InLast = 1'b1;
    InValid = 1'b1;
    #1;
    chk("bp_last_stall", 32'(InReady), 32'h0);
    idle(1);
    chk("bp_last_stall2", 32'(InReady), 32'h0);
    chk("bp_hold_xs", 32'(XS), 32'h02);
    chk("bp_hold_xc", 32'(XC), 32'h02);
    chk("bp_hold_yo", 32'(YO), 32'h07);
    OutReady = 1'b1;
    #1;
    chk("bp_release_ready", 32'(InReady), 32'h1);
    // Output transfer and last-beat transfer happen on the same edge.
    // Packet 2 = 0x10 + 0x20 + 0x30: S/C go 10/0, then 30/0, then 00/60.
    @(posedge CLK);
    #1;
    InValid = 1'b0;
    InLast = 1'b0;
    chk("bp_p2_valid", 32'(OutValid), 32'h1);
    chk("bp_p2_xs", 32'(XS), 32'h00);
    chk("bp_p2_xc", 32'(XC), 32'h60);
    chk("bp_p2_yo", 32'(YO), 32'h55);

    // Packet 2 is consumed on the same edge at which the next last beat lands
    send(8'h42, 1'b1, 8'h99);
    chk("swap_valid", 32'(OutValid), 32'h1);
    chk("swap_xs", 32'(XS), 32'h42);
    chk("swap_xc", 32'(XC), 32'h00);
    chk("swap_yo", 32'(YO), 32'h99);
    idle(1);
    chk("swap_drained", 32'(OutValid), 32'h0);
    // Packets delivered so far: p1, single, wrap, gap, bp1, bp2, swap
    chk("pkt_count", 32'(out_cnt), 32'd7);

    // Reset mid-packet discards the partial sum
    send(8'h09, 1'b0, 8'h0);
    send(8'h09, 1'b0, 8'h0);
    RSTN = 1'b0;
    InLast = 1'b1;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'h0);
    chk("midrst_inready", 32'(InReady), 32'h1);
    InLast = 1'b0;
    idle(1);
    RSTN = 1'b1;
    idle(1);
    send(8'h01, 1'b1, 8'h03);
    chk("midrst_valid", 32'(OutValid), 32'h1);
    chk("midrst_sum", 32'(8'(XS + XC)), 32'h01);
    chk("midrst_xs", 32'(XS), 32'h01);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
